controle_partida: RTL and testbench

Round sequencer for the lives/score datapath of the game. Accepts shot attempts from the input stage through a ready/valid handshake, classifies each as hit or miss, and advances a saturating miss counter and a hit counter. Holds a feedback message for a fixed number of cycles after each shot, then declares victory or defeat when a limit is reached. The miss counter uses the lives encoding used elsewhere in the design: 00, 01, 10, 11, with 11 meaning no lives remain.

---
 rtl/partida_pkg.sv | 33 +++
 rtl/contador_saturado.sv | 51 +++++
 rtl/controle_partida.sv | 180 ++++++++++++++++++
 tb/tb_controle_partida.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/partida_pkg.sv
// ----------------------------------------------------------------------------
// partida_pkg
// Shared definitions for the round sequencer of the game:
//   - state codes of the controle_partida FSM (3-bit, also exported on `estado`)
//   - widths of the hit counter, miss counter and message timer
//   - lives encoding used by the miss counter (00 = full lives, 11 = none left)
// No ports; imported by controle_partida and contador_saturado.
// ----------------------------------------------------------------------------
package partida_pkg;

  localparam int ESTADO_W  = 3;
  localparam int ACERTOS_W = 4;
  localparam int ERROS_W   = 2;
  localparam int TIMER_W   = 4;

  localparam logic [ERROS_W-1:0] VIDAS_CHEIA = 2'b00;
  localparam logic [ERROS_W-1:0] VIDAS_ZERO  = 2'b11;

  typedef enum logic [ESTADO_W-1:0] {
    OCIOSO  = 3'd0,
    ESPERA  = 3'd1,
    ACERTO  = 3'd2,
    ERRO    = 3'd3,
    VITORIA = 3'd4,
    DERROTA = 3'd5
  } estado_t;

  // True in the two terminal states, where the game is over.
  function automatic logic fim_de_jogo(input estado_t e);
    return (e == VITORIA) || (e == DERROTA);
  endfunction

endpackage

// File: rtl/contador_saturado.sv
// ----------------------------------------------------------------------------
// contador_saturado
// Up-counter that stops at LIMITE instead of wrapping.
// Parameters:
//   W       counter width
//   LIMITE  highest value the counter may reach
// Ports:
//   clock       in  system clock, rising edge
//   reset       in  synchronous, active-low reset (count goes to 0)
//   limpa       in  synchronous clear, takes priority over increment
//   incrementa  in  increment enable
//   contagem    out current count
// ----------------------------------------------------------------------------
module contador_saturado
  import partida_pkg::*;
#(
  parameter int             W      = 4,
  parameter logic [W-1:0]   LIMITE = '1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         limpa,
  input  logic         incrementa,
  output logic [W-1:0] contagem
);

  logic [W-1:0] contagem_q;
  logic [W-1:0] contagem_d;

  // The less-than test also holds any value above LIMITE rather than
  // letting it run on to the wrap point.
  always_comb begin
    contagem_d = contagem_q;
    if (limpa) begin
      contagem_d = '0;
    end else if (incrementa && (contagem_q < LIMITE)) begin
      contagem_d = contagem_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      contagem_q <= '0;
    end else begin
      contagem_q <= contagem_d;
    end
  end

  assign contagem = contagem_q;

endmodule

// File: rtl/controle_partida.sv
// ----------------------------------------------------------------------------
// controle_partida
// Round sequencer: accepts shots through a ready/valid handshake
// (pronto/jogada), counts hits and misses with saturating counters, holds a
// hit or miss message for TEMPO_MSG cycles after every shot and then ends the
// game with victory (NUM_ALVOS hits) or defeat (MAX_ERROS misses).
// Parameters:
//   NUM_ALVOS  hits needed for victory   (1..15)
//   MAX_ERROS  misses that cause defeat  (1..3)
//   TEMPO_MSG  message length in cycles  (1..15)
// Ports:
//   clock       in  system clock, rising edge
//   reset       in  synchronous, active-low reset
//   iniciar     in  start/restart request (level)
//   jogada      in  shot valid
//   acerto      in  hit flag, meaningful with jogada
//   pronto      out ready to accept a shot
//   erros       out miss count in lives encoding (saturates at MAX_ERROS)
//   acertos     out hit count (saturates at NUM_ALVOS)
//   msg_acerto  out hit message active
//   msg_erro    out miss message active
//   fim         out game over
//   vitoria     out game over with a win
//   derrota     out game over with a loss
//   estado      out current state code, for debug/display
// All outputs are decoded from flops only; no input reaches an output
// combinationally.
// ----------------------------------------------------------------------------
module controle_partida
  import partida_pkg::*;
#(
  parameter int NUM_ALVOS = 5,
  parameter int MAX_ERROS = 3,
  parameter int TEMPO_MSG = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 iniciar,
  input  logic                 jogada,
  input  logic                 acerto,
  output logic                 pronto,
  output logic [ERROS_W-1:0]   erros,
  output logic [ACERTOS_W-1:0] acertos,
  output logic                 msg_acerto,
  output logic                 msg_erro,
  output logic                 fim,
  output logic                 vitoria,
  output logic                 derrota,
  output logic [ESTADO_W-1:0]  estado
);

  localparam logic [ACERTOS_W-1:0] LIMITE_ACERTOS = ACERTOS_W'(NUM_ALVOS);
  localparam logic [ERROS_W-1:0]   LIMITE_ERROS   = ERROS_W'(MAX_ERROS);
  // The timer counts down to zero inclusive, so loading TEMPO_MSG-1 keeps
  // the message up for exactly TEMPO_MSG cycles.
  localparam logic [TIMER_W-1:0]   CARGA_TIMER    = TIMER_W'(TEMPO_MSG - 1);

  estado_t              estado_q;
  estado_t              estado_d;
  logic [TIMER_W-1:0]   timer_q;
  logic [TIMER_W-1:0]   timer_d;

  logic                 limpa_contadores;
  logic                 inc_acertos;
  logic                 inc_erros;
  logic [ACERTOS_W-1:0] acertos_cnt;
  logic [ERROS_W-1:0]   erros_cnt;

  contador_saturado #(
    .W      (ACERTOS_W),
    .LIMITE (LIMITE_ACERTOS)
  ) u_cont_acertos (
    .clock      (clock),
    .reset      (reset),
    .limpa      (limpa_contadores),
    .incrementa (inc_acertos),
    .contagem   (acertos_cnt)
  );

  contador_saturado #(
    .W      (ERROS_W),
    .LIMITE (LIMITE_ERROS)
  ) u_cont_erros (
    .clock      (clock),
    .reset      (reset),
    .limpa      (limpa_contadores),
    .incrementa (inc_erros),
    .contagem   (erros_cnt)
  );

  // Next-state logic. jogada is only looked at in ESPERA and iniciar only in
  // the idle/terminal states, so a restart request always beats a
  // simultaneous shot and no shot is ever remembered for later.
  always_comb begin
    estado_d         = estado_q;
    timer_d          = timer_q;
    limpa_contadores = 1'b0;
    inc_acertos      = 1'b0;
    inc_erros        = 1'b0;

    case (estado_q)
      OCIOSO, VITORIA, DERROTA: begin
        if (iniciar) begin
          limpa_contadores = 1'b1;
          timer_d          = '0;
          estado_d         = ESPERA;
        end
      end

      ESPERA: begin
        if (jogada) begin
          timer_d = CARGA_TIMER;
          if (acerto) begin
            inc_acertos = 1'b1;
            estado_d    = ACERTO;
          end else begin
            inc_erros = 1'b1;
            estado_d  = ERRO;
          end
        end
      end

      ACERTO: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (acertos_cnt == LIMITE_ACERTOS) begin
          estado_d = VITORIA;
        end else begin
          estado_d = ESPERA;
        end
      end

      ERRO: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (erros_cnt == LIMITE_ERROS) begin
          estado_d = DERROTA;
        end else begin
          estado_d = ESPERA;
        end
      end

      // Codes 6 and 7: recover to a clean idle game.
      default: begin
        estado_d         = OCIOSO;
        timer_d          = '0;
        limpa_contadores = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      timer_q  <= '0;
    end else begin
      estado_q <= estado_d;
      timer_q  <= timer_d;
    end
  end

  // Moore output decode. Counters are forced to their cleared value in
  // OCIOSO so that state reads as all zeros.
  always_comb begin
    pronto     = (estado_q == ESPERA);
    msg_acerto = (estado_q == ACERTO);
    msg_erro   = (estado_q == ERRO);
    vitoria    = (estado_q == VITORIA);
    derrota    = (estado_q == DERROTA);
    fim        = fim_de_jogo(estado_q);
    estado     = estado_q;
    erros      = erros_cnt;
    acertos    = acertos_cnt;
    if (estado_q == OCIOSO) begin
      erros   = VIDAS_CHEIA;
      acertos = '0;
    end
  end

endmodule

// File: tb/tb_controle_partida.sv
// ----------------------------------------------------------------------------
// tb_controle_partida
// Scoreboard bench for controle_partida. A driver applies one cycle of inputs
// at a time, advances a rule-level game model (plain integer counts and a
// remaining-message-cycles count) and, after the clock edge, queues the
// outputs the game should show. A monitor on the falling edge pops each
// expectation and compares it with the DUT outputs.
// ----------------------------------------------------------------------------
module tb_controle_partida;

  localparam int NUM_ALVOS = 5;
  localparam int MAX_ERROS = 3;
  localparam int TEMPO_MSG = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       jogada;
  logic       acerto;
  logic       pronto;
  logic [1:0] erros;
  logic [3:0] acertos;
  logic       msg_acerto;
  logic       msg_erro;
  logic       fim;
  logic       vitoria;
  logic       derrota;
  logic [2:0] estado;

  always #5 clock = ~clock;

  controle_partida #(
    .NUM_ALVOS (NUM_ALVOS),
    .MAX_ERROS (MAX_ERROS),
    .TEMPO_MSG (TEMPO_MSG)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .iniciar    (iniciar),
    .jogada     (jogada),
    .acerto     (acerto),
    .pronto     (pronto),
    .erros      (erros),
    .acertos    (acertos),
    .msg_acerto (msg_acerto),
    .msg_erro   (msg_erro),
    .fim        (fim),
    .vitoria    (vitoria),
    .derrota    (derrota),
    .estado     (estado)
  );

  typedef struct packed {
    logic       pronto;
    logic [1:0] erros;
    logic [3:0] acertos;
    logic       msg_acerto;
    logic       msg_erro;
    logic       fim;
    logic       vitoria;
    logic       derrota;
    logic [2:0] estado;
  } saida_t;

  saida_t fila[$];
  int     tests_run    = 0;
  int     tests_failed = 0;

  // Game model: what phase of the game we are in, plus plain counts.
  typedef enum {PARADO, JOGANDO, MOSTRA_ACERTO, MOSTRA_ERRO, GANHOU, PERDEU} fase_t;
  fase_t fase      = PARADO;
  int    hits      = 0;
  int    misses    = 0;
  int    msg_resta = 0;

  // Spacing measurement between accepted hits while jogada is held high.
  logic       medir_espaco = 1'b0;
  int         ciclo        = 0;
  int         ciclo_ant    = -1;
  logic [3:0] acertos_ant  = '0;

  task automatic modelo_passo(input logic r, input logic i, input logic j, input logic a);
    if (!r) begin
      fase = PARADO; hits = 0; misses = 0; msg_resta = 0;
    end else begin
      case (fase)
        PARADO, GANHOU, PERDEU: begin
          if (i) begin
            hits = 0; misses = 0; fase = JOGANDO;
          end
        end
        JOGANDO: begin
          if (j) begin
            msg_resta = TEMPO_MSG;
            if (a) begin
              if (hits < NUM_ALVOS) hits++;
              fase = MOSTRA_ACERTO;
            end else begin
              if (misses < MAX_ERROS) misses++;
              fase = MOSTRA_ERRO;
            end
          end
        end
        MOSTRA_ACERTO: begin
          msg_resta--;
          if (msg_resta == 0) fase = (hits == NUM_ALVOS) ? GANHOU : JOGANDO;
        end
        MOSTRA_ERRO: begin
          msg_resta--;
          if (msg_resta == 0) fase = (misses == MAX_ERROS) ? PERDEU : JOGANDO;
        end
        default: fase = PARADO;
      endcase
    end
  endtask

  function automatic saida_t esperado();
    saida_t s;
    s = '0;
    if (fase != PARADO) begin
      s.acertos = 4'(hits);
      s.erros   = 2'(misses);
    end
    case (fase)
      PARADO:        s.estado = 3'd0;
      JOGANDO:       begin s.estado = 3'd1; s.pronto = 1'b1; end
      MOSTRA_ACERTO: begin s.estado = 3'd2; s.msg_acerto = 1'b1; end
      MOSTRA_ERRO:   begin s.estado = 3'd3; s.msg_erro = 1'b1; end
      GANHOU:        begin s.estado = 3'd4; s.fim = 1'b1; s.vitoria = 1'b1; end
      PERDEU:        begin s.estado = 3'd5; s.fim = 1'b1; s.derrota = 1'b1; end
      default:       s.estado = 3'd0;
    endcase
    return s;
  endfunction

  // One cycle of stimulus: drive, predict, let the edge happen, queue the
  // prediction for the monitor.
  task automatic apply_stimulus(input logic r, input logic i, input logic j, input logic a);
    reset   = r;
    iniciar = i;
    jogada  = j;
    acerto  = a;
    modelo_passo(r, i, j, a);
    @(posedge clock);
    fila.push_back(esperado());
    #2;
  endtask

  task automatic check_output(input saida_t exp);
    saida_t act;
    act = '{pronto, erros, acertos, msg_acerto, msg_erro, fim, vitoria, derrota, estado};
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL saidas t=%0t: got pronto=%b erros=%b acertos=%0d msgA=%b msgE=%b fim=%b vit=%b der=%b estado=%0d, want pronto=%b erros=%b acertos=%0d msgA=%b msgE=%b fim=%b vit=%b der=%b estado=%0d",
               $time, act.pronto, act.erros, act.acertos, act.msg_acerto, act.msg_erro,
               act.fim, act.vitoria, act.derrota, act.estado,
               exp.pronto, exp.erros, exp.acertos, exp.msg_acerto, exp.msg_erro,
               exp.fim, exp.vitoria, exp.derrota, exp.estado);
    end
  endtask

  // Monitor: compares every presented output set against the scoreboard,
  // and while requested measures spacing between successive hit acceptances.
  always @(negedge clock) begin
    ciclo++;
    if (fila.size() > 0) begin
      check_output(fila.pop_front());
    end
    if (medir_espaco) begin
      if ((acertos != acertos_ant) && (acertos != 4'd0)) begin
        if (ciclo_ant >= 0) begin
          tests_run++;
          if ((ciclo - ciclo_ant) != TEMPO_MSG + 1) begin
            tests_failed++;
            $display("[TB] FAIL espacamento: got %0d cycles, want %0d",
                     ciclo - ciclo_ant, TEMPO_MSG + 1);
          end
        end
        ciclo_ant = ciclo;
      end
    end else begin
      ciclo_ant = -1;
    end
    acertos_ant = acertos;
  end

  initial begin
    reset = 1'b0; iniciar = 1'b0; jogada = 1'b0; acerto = 1'b0;

    // Reset and idle with stray shots.
    repeat (2) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1);

    // Five hits with jogada held high: one count per ESPERA visit, victory.
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    medir_espaco = 1'b1;
    repeat (32) apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1);
    medir_espaco = 1'b0;

    // Three misses, then extra shots in DERROTA.
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (20) apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (4) begin
      apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Restart priority: iniciar and jogada together in DERROTA.
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (2) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Mixed: hit, miss, hit, miss, miss -> DERROTA with 2 hits.
    begin
      logic [4:0] seq;
      seq = 5'b00101;
      for (int k = 0; k < 5; k++) begin
        apply_stimulus(1'b1, 1'b0, 1'b1, seq[k]);
        repeat (TEMPO_MSG) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      end
      repeat (2) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Reset in the second cycle of a miss message.
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized play.
    for (int k = 0; k < 3000; k++) begin
      apply_stimulus(($urandom_range(99) >= 2) ? 1'b1 : 1'b0,
                     ($urandom_range(99) < 8)  ? 1'b1 : 1'b0,
                     1'($urandom_range(1)),
                     1'($urandom_range(1)));
    end

    // Drain the scoreboard within a bounded number of cycles.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4 && fila.size() > 0; k++) @(negedge clock);
    #1;
    if (fila.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL fila: got %0d pending, want 0", fila.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
